shadow_capture_v3: RTL and testbench

SHADOW_CAPTURE_V3 -- requirements
Module: shadow_capture_v3

---
 rtl/shadow_capture_v3.sv | 150 +++++++++++++++
 tb/tb_shadow_capture_v3.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_capture_v3.sv
// Shadow capture buffer: samples an asynchronous strobe/data pair into a small
// memory, then hands the captured samples out one per read request.
module shadow_capture_v3 #(
    parameter int WIDTH     = 1,
    parameter int DEPTH     = 16,
    parameter int RING_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_en,
    input  logic                     d_clk,
    input  logic [WIDTH-1:0]         d_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         d_out,
    output logic                     d_valid,
    output logic                     d_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped,
    output logic [1:0]               dbg_state
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [AW:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [AW:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             d_valid_q, d_valid_d;

    logic             dclk_s1_q, dclk_s2_q, dclk_s3_q;
    logic [WIDTH-1:0] din_s1_q, din_s2_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             evt;
    logic             mem_we;

    assign evt = dclk_s2_q & ~dclk_s3_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        d_out_d   = d_out_q;
        d_valid_d = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (c_en) begin
                    state_d   = S_CAPTURE;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    count_d   = '0;
                    wrapped_d = 1'b0;
                end
            end

            S_CAPTURE: begin
                // The write is taken even when c_en drops in the same cycle.
                if (evt) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (count_q != CNT_FULL) begin
                        count_d = count_q + 1'b1;
                    end else if (RING_MODE != 0) begin
                        wrapped_d = 1'b1;
                    end
                end
                if (!c_en || (RING_MODE == 0 && evt && count_q == CNT_LAST)) begin
                    state_d  = S_DONE;
                    rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
                end
            end

            S_DONE, S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd_en) begin
                    d_valid_d = 1'b1;
                    d_out_d   = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    count_d   = count_q - 1'b1;
                    state_d   = (count_q == CNT_ONE) ? S_IDLE : S_DRAIN;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            d_out_q   <= '0;
            d_valid_q <= 1'b0;
            dclk_s1_q <= 1'b0;
            dclk_s2_q <= 1'b0;
            dclk_s3_q <= 1'b0;
            din_s1_q  <= '0;
            din_s2_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            dclk_s1_q <= d_clk;
            dclk_s2_q <= dclk_s1_q;
            dclk_s3_q <= dclk_s2_q;
            din_s1_q  <= d_in;
            din_s2_q  <= din_s1_q;
        end
    end

    // Sample memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= din_s2_q;
        end
    end

    assign d_out     = d_out_q;
    assign d_valid   = d_valid_q;
    assign d_ready   = (state_q == S_DONE) || (state_q == S_DRAIN);
    assign count     = count_q;
    assign wrapped   = (RING_MODE != 0) && wrapped_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shadow_capture_v3.sv
// Bench for shadow_capture_v3: one-shot and ring instances share stimulus and
// are each checked against a queue model of what they should have captured.
module tb_shadow_capture_v3;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst, c_en, d_clk, rd_en;
    logic [W-1:0] d_in;

    logic [W-1:0] d_out0, d_out1;
    logic         d_valid0, d_valid1, d_ready0, d_ready1, wrapped0, wrapped1;
    logic [2:0]   count0, count1;
    logic [1:0]   st0, st1;

    shadow_capture_v3 #(.WIDTH(W), .DEPTH(D), .RING_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .c_en(c_en), .d_clk(d_clk), .d_in(d_in),
        .rd_en(rd_en), .d_out(d_out0), .d_valid(d_valid0), .d_ready(d_ready0),
        .count(count0), .wrapped(wrapped0), .dbg_state(st0)
    );

    shadow_capture_v3 #(.WIDTH(W), .DEPTH(D), .RING_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .c_en(c_en), .d_clk(d_clk), .d_in(d_in),
        .rd_en(rd_en), .d_out(d_out1), .d_valid(d_valid1), .d_ready(d_ready1),
        .count(count1), .wrapped(wrapped1), .dbg_state(st1)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    bit           cap0;
    bit           wrap1;
    logic [W-1:0] last0, last1;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One-shot keeps the first D samples; ring keeps the newest D.
    function automatic void model_push(input logic [W-1:0] v);
        if (cap0) begin
            exp0_q.push_back(v);
            if (exp0_q.size() == D) cap0 = 1'b0;
        end
        exp1_q.push_back(v);
        if (exp1_q.size() > D) begin
            void'(exp1_q.pop_front());
            wrap1 = 1'b1;
        end
    endfunction

    function automatic void model_clear();
        exp0_q.delete();
        exp1_q.delete();
        cap0  = 1'b1;
        wrap1 = 1'b0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_dout0"}, 16'(d_out0), 16'h0);
        check_eq({tag, "_dout1"}, 16'(d_out1), 16'h0);
        check_eq({tag, "_dval0"}, 16'(d_valid0), 16'h0);
        check_eq({tag, "_dval1"}, 16'(d_valid1), 16'h0);
        check_eq({tag, "_rdy0"}, 16'(d_ready0), 16'h0);
        check_eq({tag, "_rdy1"}, 16'(d_ready1), 16'h0);
        check_eq({tag, "_cnt0"}, 16'(count0), 16'h0);
        check_eq({tag, "_cnt1"}, 16'(count1), 16'h0);
        check_eq({tag, "_wrap0"}, 16'(wrapped0), 16'h0);
        check_eq({tag, "_wrap1"}, 16'(wrapped1), 16'h0);
    endtask

    task automatic start_capture();
        c_en = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    task automatic pulse(input logic [W-1:0] v);
        d_in  = v;
        d_clk = 1'b1;
        model_push(v);
        repeat (3) @(negedge clk);
        d_clk = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("cap_cnt0", 16'(count0), 16'(exp0_q.size()));
        check_eq("cap_cnt1", 16'(count1), 16'(exp1_q.size()));
        check_eq("cap_wrap1", 16'(wrapped1), 16'(wrap1));
    endtask

    // An empty capture shows d_ready for exactly one cycle; otherwise it stays up.
    task automatic stop_capture();
        int hi0 = 0;
        int hi1 = 0;
        c_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (d_ready0) hi0++;
            if (d_ready1) hi1++;
        end
        check_eq("rdy_cycles0", 16'(hi0), (exp0_q.size() == 0) ? 16'd1 : 16'd3);
        check_eq("rdy_cycles1", 16'(hi1), (exp1_q.size() == 0) ? 16'd1 : 16'd3);
        check_eq("done_cnt0", 16'(count0), 16'(exp0_q.size()));
        check_eq("done_cnt1", 16'(count1), 16'(exp1_q.size()));
        check_eq("done_wrap0", 16'(wrapped0), 16'h0);
        check_eq("done_wrap1", 16'(wrapped1), 16'(wrap1));
    endtask

    task automatic coincident_stop(input logic [W-1:0] v);
        d_in  = v;
        d_clk = 1'b1;
        repeat (2) @(negedge clk);
        model_push(v);
        stop_capture();
        d_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain();
        int           guard = 0;
        int           extra = 0;
        bit           f0, f1;
        logic [W-1:0] e0 = '0;
        logic [W-1:0] e1 = '0;
        while ((exp0_q.size() > 0 || exp1_q.size() > 0 || extra < 3) && guard < 200) begin
            if (exp0_q.size() == 0 && exp1_q.size() == 0) begin
                rd_en = 1'b1;
                extra++;
            end else begin
                rd_en = ($urandom_range(0, 3) != 0);
            end
            f0 = rd_en && (exp0_q.size() > 0);
            f1 = rd_en && (exp1_q.size() > 0);
            if (f0) e0 = exp0_q.pop_front();
            if (f1) e1 = exp1_q.pop_front();
            @(negedge clk);
            check_eq("rd_valid0", 16'(d_valid0), 16'(f0));
            check_eq("rd_valid1", 16'(d_valid1), 16'(f1));
            if (f0) last0 = e0;
            if (f1) last1 = e1;
            check_eq("rd_dout0", 16'(d_out0), 16'(last0));
            check_eq("rd_dout1", 16'(d_out1), 16'(last1));
            check_eq("rd_ready0", 16'(d_ready0), 16'(exp0_q.size() > 0));
            check_eq("rd_ready1", 16'(d_ready1), 16'(exp1_q.size() > 0));
            check_eq("rd_cnt0", 16'(count0), 16'(exp0_q.size()));
            check_eq("rd_cnt1", 16'(count1), 16'(exp1_q.size()));
            guard++;
        end
        rd_en = 1'b0;
        if (guard >= 200) check_eq("drain_timeout", 16'(exp0_q.size() + exp1_q.size()), 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst   = 1'b1;
        c_en  = 1'b0;
        d_clk = 1'b0;
        d_in  = '0;
        rd_en = 1'b0;
        last0 = '0;
        last1 = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Four samples fill the one-shot buffer exactly.
        start_capture();
        pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
        check_eq("full_rdy0", 16'(d_ready0), 16'h1);
        stop_capture();
        drain();

        // Samples past full are dropped (one-shot) or overwrite oldest (ring).
        start_capture();
        pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44); pulse(8'hEE); pulse(8'h55);
        stop_capture();
        drain();

        start_capture();
        for (int i = 1; i <= 6; i++) pulse(8'(i));
        stop_capture();
        drain();

        // Enable pulse with no strobes.
        start_capture();
        stop_capture();
        drain();

        // Reset in the middle of a capture discards it.
        start_capture();
        pulse(8'h5A); pulse(8'hC3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst   = 1'b0;
        last0 = '0;
        last1 = '0;
        @(negedge clk);
        model_clear();
        pulse(8'hA5);
        stop_capture();
        drain();

        // Strobe landing in the cycle enable falls is still captured.
        start_capture();
        pulse(8'h3C);
        coincident_stop(8'h7E);
        drain();
        check_eq("coinc_last0", 16'(d_out0), 16'h7E);
        check_eq("coinc_last1", 16'(d_out1), 16'h7E);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 9);
            start_capture();
            for (int i = 0; i < n; i++) pulse(8'($urandom_range(0, 255)));
            stop_capture();
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
